timer_bank: RTL and testbench

Multi-channel, parametrised successor to the single free-running clock counter on the picorv32 system bus. It provides NCH independent timer channels. Each channel has a prescaler, an up-counter, a compare register, auto-reload and one-shot modes, sticky match flags and a combined interrupt line. It occupies one 256-byte decode slot. It uses the same one-wait-state `cs`/`rdy` handshake as the other system-bus peripherals.

---
 rtl/timer_bank.sv | 212 +++++++++++++++++++++
 tb/tb_timer_bank.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: NCH independent timer channels on the picorv32 system bus.
// Each channel has a counter, compare register, auto-reload and one-shot
// modes, a sticky MATCH flag and an interrupt enable. Per-channel register
// words: 0 CTRL, 1 CNT, 2 CMP, 3 PRESC. Accesses use the one-wait-state
// cs/rdy handshake.
// Optional feature: define TIMER_BANK_PRESCALE_EN to build the per-channel
// prescaler (pcnt and PRESC). Without it every enabled cycle is a tick and
// PRESC reads as 0.
module timer_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int PSW   = 16
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic        cs,
    input  logic [3:0]  we,
    input  logic [5:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        rdy,
    output logic        irq
);

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_CNT   = 2'd1;
    localparam logic [1:0] REG_CMP   = 2'd2;
    localparam logic [1:0] REG_PRESC = 2'd3;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [NCH-1:0]   r_en;
    logic [NCH-1:0]   r_ar;
    logic [NCH-1:0]   r_os;
    logic [NCH-1:0]   r_ie;
    logic [NCH-1:0]   r_match;
    logic [WIDTH-1:0] r_cnt [NCH];
    logic [WIDTH-1:0] r_cmp [NCH];
`ifdef TIMER_BANK_PRESCALE_EN
    logic [PSW-1:0]   r_presc [NCH];
    logic [PSW-1:0]   r_pcnt  [NCH];
`endif
    logic [31:0]      r_dout;
    logic             r_rdy;
    logic             r_irq;

    logic             w_acc;
    logic             w_wr;
    logic [1:0]       w_reg;
    logic [NCH-1:0]   w_sel;
    logic [NCH-1:0]   w_tick;
    logic [NCH-1:0]   w_hit;
    logic [31:0]      w_rdata;
    logic [31:0]      w_wdata;
    logic             w_unused;

    assign dout = r_dout;
    assign rdy  = r_rdy;
    assign irq  = r_irq;

    // The merged write word is only partly consumed for narrow fields.
`ifdef TIMER_BANK_PRESCALE_EN
    assign w_unused = ^w_wdata;
`else
    assign w_unused = ^{w_wdata, PSW[0]};
`endif

    // Decode the access and form the addressed register's read/merge value.
    always_comb begin
        w_acc   = cs & ~r_rdy;
        w_wr    = w_acc & (|we);
        w_reg   = addr[1:0];
        w_rdata = 32'd0;
        w_sel   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(addr[5:2]) == i) begin
                w_sel[i] = w_wr;
                case (w_reg)
                    REG_CTRL:  w_rdata = {23'd0, r_match[i], 4'd0,
                                          r_ie[i], r_os[i], r_ar[i], r_en[i]};
                    REG_CNT:   w_rdata = 32'(r_cnt[i]);
                    REG_CMP:   w_rdata = 32'(r_cmp[i]);
`ifdef TIMER_BANK_PRESCALE_EN
                    REG_PRESC: w_rdata = 32'(r_presc[i]);
`else
                    REG_PRESC: w_rdata = 32'd0;
`endif
                    default:   w_rdata = 32'd0;
                endcase
            end else begin
                w_sel[i] = 1'b0;
            end
        end
        w_wdata = merge_lanes(w_rdata, din, we);
    end

    // Per-channel tick and compare-hit detection.
    always_comb begin
        w_tick = '0;
        w_hit  = '0;
        for (int i = 0; i < NCH; i++) begin
`ifdef TIMER_BANK_PRESCALE_EN
            w_tick[i] = r_en[i] & (r_pcnt[i] == r_presc[i]);
`else
            w_tick[i] = r_en[i];
`endif
            w_hit[i] = w_tick[i] & (r_cnt[i] == r_cmp[i]);
        end
    end

    // Bus handshake, registered read data and combined interrupt.
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_rdy  <= 1'b0;
            r_dout <= 32'd0;
            r_irq  <= 1'b0;
        end else begin
            r_rdy <= cs & ~r_rdy;
            if (w_acc) begin
                r_dout <= w_rdata;
            end else begin
                r_dout <= r_dout;
            end
            r_irq <= |(r_match & r_ie);
        end
    end

    // Channel control bits, counter and compare; bus CNT writes beat ticks.
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_en    <= '0;
            r_ar    <= '0;
            r_os    <= '0;
            r_ie    <= '0;
            r_match <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
                r_cmp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_sel[i] && (w_reg == REG_CTRL)) begin
                    r_ar[i] <= w_wdata[1];
                    r_os[i] <= w_wdata[2];
                    r_ie[i] <= w_wdata[3];
                end
                // A one-shot hit disables the channel even against a CTRL write.
                if (w_hit[i] && r_os[i]) begin
                    r_en[i] <= 1'b0;
                end else if (w_sel[i] && (w_reg == REG_CTRL)) begin
                    r_en[i] <= w_wdata[0];
                end
                // A hit setting MATCH wins over a simultaneous W1C.
                if (w_hit[i]) begin
                    r_match[i] <= 1'b1;
                end else if (w_sel[i] && (w_reg == REG_CTRL) && we[1] && din[8]) begin
                    r_match[i] <= 1'b0;
                end
                if (w_sel[i] && (w_reg == REG_CNT)) begin
                    r_cnt[i] <= w_wdata[WIDTH-1:0];
                end else if (w_hit[i] && r_ar[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_tick[i]) begin
                    r_cnt[i] <= r_cnt[i] + WIDTH'(1);
                end
                if (w_sel[i] && (w_reg == REG_CMP)) begin
                    r_cmp[i] <= w_wdata[WIDTH-1:0];
                end
            end
        end
    end

`ifdef TIMER_BANK_PRESCALE_EN
    // Prescaler: pcnt runs while enabled, restarts on a tick or a CNT write.
    always_ff @(posedge clk24) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_presc[i] <= '0;
                r_pcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_sel[i] && (w_reg == REG_PRESC)) begin
                    r_presc[i] <= w_wdata[PSW-1:0];
                end
                if (w_sel[i] && (w_reg == REG_CNT)) begin
                    r_pcnt[i] <= '0;
                end else if (w_tick[i]) begin
                    r_pcnt[i] <= '0;
                end else if (r_en[i]) begin
                    r_pcnt[i] <= r_pcnt[i] + PSW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_timer_bank.sv
// Testbench for timer_bank: directed scenarios plus randomized bus traffic,
// checked every cycle against a behavioural model of the timer channels.
// Honours TIMER_BANK_PRESCALE_EN the same way the design does.
module tb_timer_bank;

    localparam int NCH  = 4;
    localparam int W    = 8;
    localparam int PSW  = 4;
    localparam int CMOD = 1 << W;
    localparam int PMOD = 1 << PSW;
`ifdef TIMER_BANK_PRESCALE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic        clk24 = 1'b0;
    logic        reset;
    logic        cs;
    logic [3:0]  we;
    logic [5:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        rdy;
    logic        irq;

    timer_bank #(.NCH(NCH), .WIDTH(W), .PSW(PSW)) dut (
        .clk24 (clk24),
        .reset (reset),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .rdy   (rdy),
        .irq   (irq)
    );

    always #5 clk24 = ~clk24;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: one entry per channel, plain integers.
    bit          m_en    [NCH];
    bit          m_ar    [NCH];
    bit          m_os    [NCH];
    bit          m_ie    [NCH];
    bit          m_match [NCH];
    int          m_cnt   [NCH];
    int          m_cmp   [NCH];
    int          m_presc [NCH];
    int          m_pcnt  [NCH];
    bit          m_rdy  = 1'b0;
    bit          m_irq  = 1'b0;
    logic [31:0] m_dout = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] ra(input int ch, input int rg);
        return {4'(ch), 2'(rg)};
    endfunction

    function automatic logic [31:0] model_read(input int ch, input int rg);
        if (ch >= NCH) return 32'd0;
        case (rg)
            0:       return {23'd0, m_match[ch], 4'd0, m_ie[ch], m_os[ch], m_ar[ch], m_en[ch]};
            1:       return 32'(m_cnt[ch]);
            2:       return 32'(m_cmp[ch]);
            3:       return PRE ? 32'(m_presc[ch]) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Advance the model by one clock using the current inputs, clock the DUT, compare.
    task automatic step();
        bit acc, tick, hit, sel, old_os, irq_n;
        int ch, rg;
        logic [31:0] rd, mv;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_ar[c] = 0; m_os[c] = 0; m_ie[c] = 0; m_match[c] = 0;
                m_cnt[c] = 0; m_cmp[c] = 0; m_presc[c] = 0; m_pcnt[c] = 0;
            end
            m_rdy = 0; m_irq = 0; m_dout = 32'd0;
        end else begin
            acc = cs && !m_rdy;
            ch  = int'(addr[5:2]);
            rg  = int'(addr[1:0]);
            rd  = model_read(ch, rg);
            mv  = lanes(rd, din, we);
            irq_n = 0;
            for (int c = 0; c < NCH; c++) if (m_match[c] && m_ie[c]) irq_n = 1;
            for (int c = 0; c < NCH; c++) begin
                tick   = m_en[c] && (!PRE || m_pcnt[c] == m_presc[c]);
                hit    = tick && (m_cnt[c] == m_cmp[c]);
                sel    = acc && (we != 4'd0) && (ch == c);
                old_os = m_os[c];
                if (PRE && m_en[c]) m_pcnt[c] = tick ? 0 : (m_pcnt[c] + 1) % PMOD;
                if (tick) m_cnt[c] = (hit && m_ar[c]) ? 0 : (m_cnt[c] + 1) % CMOD;
                if (sel) begin
                    case (rg)
                        0: begin
                            m_en[c] = mv[0]; m_ar[c] = mv[1]; m_os[c] = mv[2]; m_ie[c] = mv[3];
                            if (we[1] && din[8]) m_match[c] = 0;
                        end
                        1: begin m_cnt[c] = int'(mv & 32'(CMOD - 1)); m_pcnt[c] = 0; end
                        2: m_cmp[c] = int'(mv & 32'(CMOD - 1));
                        default: if (PRE) m_presc[c] = int'(mv & 32'(PMOD - 1));
                    endcase
                end
                if (hit) m_match[c] = 1;
                if (hit && old_os) m_en[c] = 0;
            end
            if (acc) m_dout = rd;
            m_rdy = acc;
            m_irq = irq_n;
        end
        @(posedge clk24);
        #1;
        check_eq("rdy", 32'(rdy), 32'(m_rdy));
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("dout", dout, m_dout);
    endtask

    task automatic bus(input logic [3:0] w, input logic [5:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] q);
        cs = 1'b1; we = w; addr = a; din = d;
        step();
        q = dout;
        for (int k = 1; k < hold; k++) step();
        cs = 1'b0; we = 4'd0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus(4'hF, a, d, 1, q);
        step();
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] q);
        bus(4'h0, a, 32'd0, 1, q);
        step();
    endtask

    initial begin
        logic [31:0] q;
        int pulses;
        reset = 1'b1; cs = 1'b0; we = 4'd0; addr = 6'd0; din = 32'd0;

        // Reset: two cycles, then every register reads zero.
        step(); step();
        reset = 1'b0;
        check_eq("reset_rdy", 32'(rdy), 32'd0);
        check_eq("reset_irq", 32'(irq), 32'd0);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++) begin
                rd(ra(c, r), q);
                check_eq("reset_reg", q, 32'd0);
            end

        // Auto-reload match on channel 0.
        wr(ra(0, 2), 32'd4);
        wr(ra(0, 3), 32'd0);
        wr(ra(0, 0), 32'h0B);
        repeat (20) step();
        check_eq("ar_irq", 32'(irq), 32'd1);
        rd(ra(0, 0), q);
        check_eq("ar_ctrl", q, 32'h10B);
        wr(ra(0, 0), 32'h10B);
        repeat (3) step();
        wr(ra(0, 0), 32'h0A);
        wr(ra(0, 0), 32'h108);
        check_eq("ar_irq_clear", 32'(irq), 32'd0);

        // Prescaled one-shot on channel 2.
        wr(ra(2, 3), 32'd2);
        wr(ra(2, 2), 32'd1);
        wr(ra(2, 0), 32'h05);
        repeat (40) step();
        rd(ra(2, 1), q);
        check_eq("os_cnt", q, 32'd2);
        rd(ra(2, 0), q);
        check_eq("os_ctrl", q, 32'h104);
        rd(ra(2, 3), q);
        check_eq("os_presc", q, PRE ? 32'd2 : 32'd0);

        // Wrap without match, then CNT write against a tick on channel 1.
        wr(ra(1, 1), 32'hFF);
        wr(ra(1, 2), 32'h10);
        wr(ra(1, 3), 32'd0);
        wr(ra(1, 0), 32'h01);
        wr(ra(1, 0), 32'h00);
        rd(ra(1, 1), q);
        check_eq("wrap_cnt", q, 32'h01);
        rd(ra(1, 0), q);
        check_eq("wrap_nomatch", q, 32'h00);
        wr(ra(1, 0), 32'h01);
        wr(ra(1, 1), 32'h55);
        wr(ra(1, 0), 32'h00);
        rd(ra(1, 1), q);
        check_eq("cnt_prio", q, 32'h57);

        // Back-to-back accesses with cs held two cycles each.
        pulses = 0;
        cs = 1'b1; we = 4'd0; addr = ra(0, 2);
        for (int k = 0; k < 4; k++) begin
            step();
            if (rdy) pulses++;
        end
        cs = 1'b0;
        step();
        check_eq("rdy_pulses", 32'(pulses), 32'd2);

        // Byte lanes on an 8-bit CMP field.
        wr(ra(3, 2), 32'd0);
        bus(4'b0010, ra(3, 2), 32'hAABBCCDD, 1, q); step();
        rd(ra(3, 2), q);
        check_eq("lane1_trunc", q, 32'h00);
        bus(4'b0001, ra(3, 2), 32'hAABBCCDD, 1, q); step();
        rd(ra(3, 2), q);
        check_eq("lane0", q, 32'hDD);

        // Unimplemented channel 9.
        rd(ra(9, 0), q);
        check_eq("unimpl_rd", q, 32'd0);
        wr(ra(9, 0), 32'h0F);
        wr(ra(9, 1), 32'h33);
        rd(ra(1, 0), q);
        check_eq("unimpl_nowrite", q, 32'd0);
        rd(ra(9, 1), q);
        check_eq("unimpl_rd2", q, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int r, ch, rg, pick;
            logic [3:0] w;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                reset = 1'b1; cs = 1'($urandom_range(0, 1)); addr = 6'($urandom);
                step(); step();
                reset = 1'b0; cs = 1'b0;
                step();
            end else begin
                pick = int'($urandom_range(0, 9));
                ch = (pick < 8) ? pick % 4 : int'($urandom_range(4, 15));
                rg = int'($urandom_range(0, 3));
                if ($urandom_range(0, 9) < 4) w = 4'd0;
                else if ($urandom_range(0, 3) == 0) w = 4'($urandom_range(1, 15));
                else w = 4'hF;
                case (rg)
                    0:       d = 32'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
                    1:       d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 24));
                    2:       d = 32'($urandom_range(0, 20));
                    default: d = 32'($urandom_range(0, 5));
                endcase
                bus(w, ra(ch, rg), d, int'($urandom_range(1, 2)), q);
                repeat ($urandom_range(0, 3)) step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
